// File: rtl/washer_timer.sv
`timescale 1ns/1ps
// Programmable duration timer for the washing-machine controller: a prescaler
// produces a unit tick, a down-counter measures the selected duration.
module washer_timer #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SEL0_UNITS = 30,
  parameter int MED_UNITS  = 900,
  parameter int HIGH_UNITS = 1500,
  parameter int SPIN_UNITS = 300,
  parameter int CNT_W      = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TIMER_EN,
  input  logic [1:0]       TIMER_SEL,
  output logic             TIMER_DONE,
  output logic             TIMER_BUSY,
  output logic [CNT_W-1:0] REMAIN
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRE_ZERO = PW'(0);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // A zero duration would never expire, so it is treated as one unit.
  localparam logic [CNT_W-1:0] U_SEL0 = (SEL0_UNITS == 0) ? CNT_ONE : CNT_W'(SEL0_UNITS);
  localparam logic [CNT_W-1:0] U_MED  = (MED_UNITS  == 0) ? CNT_ONE : CNT_W'(MED_UNITS);
  localparam logic [CNT_W-1:0] U_HIGH = (HIGH_UNITS == 0) ? CNT_ONE : CNT_W'(HIGH_UNITS);
  localparam logic [CNT_W-1:0] U_SPIN = (SPIN_UNITS == 0) ? CNT_ONE : CNT_W'(SPIN_UNITS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sel;
  logic [PW-1:0]    r_pre;
  logic [CNT_W-1:0] r_remain;
  logic             r_done;
  logic             r_busy;

  function automatic logic [CNT_W-1:0] units_of(input logic [1:0] sel);
    case (sel)
      2'b00:   units_of = U_SEL0;
      2'b01:   units_of = U_MED;
      2'b10:   units_of = U_HIGH;
      2'b11:   units_of = U_SPIN;
      default: units_of = U_SEL0;
    endcase
  endfunction

  // Timer FSM with prescaler, unit down-counter and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_sel    <= 2'b00;
      r_pre    <= PRE_ZERO;
      r_remain <= CNT_ZERO;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_pre  <= PRE_ZERO;
          if (TIMER_EN) begin
            r_sel    <= TIMER_SEL;
            r_remain <= units_of(TIMER_SEL);
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_remain <= CNT_ZERO;
            r_busy   <= 1'b0;
          end
        end
        S_RUN: begin
          r_done <= 1'b0;
          if (!TIMER_EN) begin
            // Abort takes priority over a coincident expiry.
            r_state  <= S_IDLE;
            r_remain <= CNT_ZERO;
            r_pre    <= PRE_ZERO;
            r_busy   <= 1'b0;
          end else if (TIMER_SEL != r_sel) begin
            r_sel    <= TIMER_SEL;
            r_remain <= units_of(TIMER_SEL);
            r_pre    <= PRE_ZERO;
          end else if (r_pre == PRE_LAST) begin
            r_pre <= PRE_ZERO;
            if (r_remain <= CNT_ONE) begin
              r_remain <= CNT_ZERO;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_EXPIRED;
            end else begin
              r_remain <= r_remain - CNT_ONE;
            end
          end else begin
            r_pre <= r_pre + PRE_ONE;
          end
        end
        S_EXPIRED: begin
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_remain <= CNT_ZERO;
          r_pre    <= PRE_ZERO;
          if (!TIMER_EN) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_EXPIRED;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_remain <= CNT_ZERO;
          r_pre    <= PRE_ZERO;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign TIMER_DONE = r_done;
  assign TIMER_BUSY = r_busy;
  assign REMAIN     = r_remain;

endmodule

// File: tb/tb_washer_timer.sv
`timescale 1ns/1ps
// Self-checking bench for washer_timer: directed scenarios plus randomized
// enable/select traffic checked against a deadline-based reference model.
module tb_washer_timer;

  localparam int TD = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TIMER_EN = 1'b0;
  logic [1:0]  TIMER_SEL = 2'b00;
  logic        TIMER_DONE;
  logic        TIMER_BUSY;
  logic [11:0] REMAIN;

  washer_timer #(
    .TICK_DIV(TD), .SEL0_UNITS(1), .MED_UNITS(3), .HIGH_UNITS(5), .SPIN_UNITS(2), .CNT_W(12)
  ) dut (
    .CLK(CLK), .RST(RST), .TIMER_EN(TIMER_EN), .TIMER_SEL(TIMER_SEL),
    .TIMER_DONE(TIMER_DONE), .TIMER_BUSY(TIMER_BUSY), .REMAIN(REMAIN)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: a run is described by its load edge and duration;
  // remaining time and expiry follow from elapsed edges by plain arithmetic.
  int units_tbl [4] = '{1, 3, 5, 2};
  int m_edge   = 0;
  int m_mode   = 0;   // 0 idle, 1 running, 2 expired-waiting-for-enable-low
  int m_load   = 0;
  int m_units  = 0;
  int m_sel    = 0;
  int m_done   = 0;
  int pulses   = 0;

  function automatic int m_remain();
    if (m_mode == 1) return m_units - (m_edge - m_load) / TD;
    else return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_done = 0; m_sel = 0;
  endtask

  task automatic model_edge(input logic en, input logic [1:0] sel);
    m_edge++;
    m_done = 0;
    if (m_mode == 0) begin
      if (en) begin
        m_mode = 1; m_load = m_edge; m_sel = int'(sel); m_units = units_tbl[sel];
      end
    end else if (m_mode == 1) begin
      if (!en) m_mode = 0;
      else if (int'(sel) != m_sel) begin
        m_load = m_edge; m_sel = int'(sel); m_units = units_tbl[sel];
      end else if (m_edge - m_load == m_units * TD) begin
        m_mode = 2; m_done = 1;
      end
    end else begin
      if (!en) m_mode = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("remain", 32'(REMAIN), 32'(m_remain()));
    chk("busy", 32'(TIMER_BUSY), (m_mode == 1) ? 32'd1 : 32'd0);
    chk("done", 32'(TIMER_DONE), 32'(m_done));
  endtask

  task automatic step();
    logic       en_s;
    logic [1:0] sel_s;
    en_s  = TIMER_EN;
    sel_s = TIMER_SEL;
    @(posedge CLK);
    model_edge(en_s, sel_s);
    #1;
    if (TIMER_DONE === 1'b1) pulses++;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Power-on reset
    #1;
    chk("rst_remain", 32'(REMAIN), 32'd0);
    chk("rst_busy", 32'(TIMER_BUSY), 32'd0);
    chk("rst_done", 32'(TIMER_DONE), 32'd0);
    @(posedge CLK); @(posedge CLK);
    #2 RST = 1'b0;
    model_reset();

    // Reset mid-run while REMAIN is 2
    TIMER_SEL = 2'b01; TIMER_EN = 1'b1;
    step();
    chk("mid_load", 32'(REMAIN), 32'd3);
    steps(4);
    chk("mid_pre", 32'(REMAIN), 32'd2);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_remain", 32'(REMAIN), 32'd0);
    chk("mid_rst_busy", 32'(TIMER_BUSY), 32'd0);
    chk("mid_rst_done", 32'(TIMER_DONE), 32'd0);
    TIMER_EN = 1'b0;
    model_reset();
    @(posedge CLK);
    #2 RST = 1'b0;
    step();

    // Medium wash: 3,2,1,0 at L, L+4, L+8, L+12
    TIMER_SEL = 2'b01; TIMER_EN = 1'b1;
    step();
    chk("med_L", 32'(REMAIN), 32'd3);
    chk("med_busy", 32'(TIMER_BUSY), 32'd1);
    steps(4); chk("med_L4", 32'(REMAIN), 32'd2);
    steps(4); chk("med_L8", 32'(REMAIN), 32'd1);
    steps(4);
    chk("med_L12_remain", 32'(REMAIN), 32'd0);
    chk("med_L12_done", 32'(TIMER_DONE), 32'd1);
    chk("med_L12_busy", 32'(TIMER_BUSY), 32'd0);
    step(); chk("med_done_fall", 32'(TIMER_DONE), 32'd0);

    // Hold enable after expiry: no second pulse
    pulses = 0;
    steps(20);
    chk("hold_pulses", 32'(pulses), 32'd0);
    TIMER_EN = 1'b0; step();
    TIMER_SEL = 2'b11; TIMER_EN = 1'b1;
    step();
    chk("spin_L", 32'(REMAIN), 32'd2);
    steps(7); chk("spin_L7_done", 32'(TIMER_DONE), 32'd0);
    step();   chk("spin_L8_done", 32'(TIMER_DONE), 32'd1);

    // Abort at L+10 on a high-water run
    TIMER_EN = 1'b0; step(); step();
    TIMER_SEL = 2'b10; TIMER_EN = 1'b1;
    step();
    chk("abort_L", 32'(REMAIN), 32'd5);
    steps(9);
    TIMER_EN = 1'b0;
    pulses = 0;
    step();
    chk("abort_remain", 32'(REMAIN), 32'd0);
    chk("abort_busy", 32'(TIMER_BUSY), 32'd0);
    steps(30);
    chk("abort_pulses", 32'(pulses), 32'd0);

    // Select change at L+5: reload to 2, expiry at L+13
    TIMER_SEL = 2'b01; TIMER_EN = 1'b1;
    step();
    steps(4);
    TIMER_SEL = 2'b11;
    step();
    chk("sel_L5", 32'(REMAIN), 32'd2);
    steps(7); chk("sel_L12_done", 32'(TIMER_DONE), 32'd0);
    step();   chk("sel_L13_done", 32'(TIMER_DONE), 32'd1);

    // Abort coincident with expiry: abort wins
    TIMER_EN = 1'b0; step(); step();
    TIMER_SEL = 2'b00; TIMER_EN = 1'b1;
    step();
    steps(3);
    TIMER_EN = 1'b0;
    step();
    chk("sim_done", 32'(TIMER_DONE), 32'd0);
    chk("sim_busy", 32'(TIMER_BUSY), 32'd0);
    chk("sim_remain", 32'(REMAIN), 32'd0);
    steps(2);

    // Random enable/select traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) TIMER_EN = ~TIMER_EN;
      if ($urandom_range(0, 15) == 0) TIMER_SEL = 2'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/washer_timer.md
# washer_timer

Programmable duration timer for the washing-machine controller. It consumes `TIMER_SEL`/`TIMER_EN` from `washing_machine_fsm` and returns the `TIMER_DONE` pulse that ends the wash (ACTIVE) and spin (SPIN) phases. A prescaler turns `CLK` into a 1-unit tick, and a down-counter measures the selected duration. A remaining-time readout drives the front-panel display.

## Interface

Parameters:
- `TICK_DIV`, default 50_000_000: `CLK` cycles per time unit (one second at 50 MHz); must be ≥ 2.
- `SEL0_UNITS`, default 30: duration for `TIMER_SEL`=00 (spare/guard timer).
- `MED_UNITS`, default 900: duration for `TIMER_SEL`=01 (medium-water wash).
- `HIGH_UNITS`, default 1500: duration for `TIMER_SEL`=10 (high-water wash).
- `SPIN_UNITS`, default 300: duration for `TIMER_SEL`=11 (spin).
- `CNT_W`, default 12: width of the unit counter; all `*_UNITS` must be in [1, 2^CNT_W−1].

Ports:
- `CLK`, input, 1: system clock, rising-edge.
- `RST`, input, 1: reset; one clock; reset is asynchronous and active-high.
- `TIMER_EN`, input, 1: run request from the FSM; level-sensitive.
- `TIMER_SEL`, input, 2: duration select.
- `TIMER_DONE`, output, 1: registered one-cycle pulse on expiry.
- `TIMER_BUSY`, output, 1: high while counting (RUN state).
- `REMAIN`, output, `CNT_W`: whole units remaining; 0 when not running.

## Operation

- Three-state FSM: IDLE, RUN, EXPIRED.
- Reset (async, `RST`=1): state IDLE; prescaler 0; `REMAIN`=0; `TIMER_DONE`=0; `TIMER_BUSY`=0; latched select 00. Outputs hold these values until the first edge after `RST` falls.
- IDLE, `TIMER_EN`=1 at an edge:
  - latch `TIMER_SEL`;
  - load `REMAIN` with the selected `*_UNITS`;
  - clear the prescaler;
  - go to RUN.
- RUN, prescaler behaviour: the prescaler counts 0..`TICK_DIV`−1. At the terminal value it wraps to 0 and `REMAIN` decrements by 1.
- RUN, expiry: when the decrement takes `REMAIN` from 1 to 0 in the same edge, set `TIMER_DONE`=1 for exactly one cycle and go to EXPIRED.
- RUN, `TIMER_EN`=0 at an edge: abort. Go to IDLE, clear `REMAIN` and the prescaler, and issue no `TIMER_DONE`. This covers the FSM leaving ACTIVE or SPIN early, e.g. on reset.
- RUN, `TIMER_SEL` differs from the latched value while `TIMER_EN`=1: restart. Reload with the new duration, clear the prescaler, stay in RUN, issue no `TIMER_DONE`.
- EXPIRED: hold `REMAIN`=0 and `TIMER_BUSY`=0. Leave for IDLE only when `TIMER_EN`=0. No auto-restart while `TIMER_EN` stays high, so exactly one pulse is issued per enable.
- Abort and expiry on the same edge: abort wins (`TIMER_EN`=0 means no pulse).
- Arithmetic:
  - `REMAIN` never underflows.
  - The prescaler width is `$clog2(TICK_DIV)`.
  - A `*_UNITS` value of 0 is clamped to 1 at elaboration.

## Timing

- Load edge L is the edge where IDLE sees `TIMER_EN`=1.
- `REMAIN` equals the selected units from L.
- The first decrement happens at edge L+`TICK_DIV`.
- `TIMER_DONE` rises at edge L+units×`TICK_DIV` and falls at the next edge.
- `TIMER_BUSY` is high from edge L up to, not including, the expiry edge.
- Re-arm: after `TIMER_EN` falls, IDLE is reached one edge later. A new run can then load at the following edge, so the minimum gap between `TIMER_EN` low and a new load is 2 edges.
- All outputs are registered; there is no combinational path from input to output.

## Test plan

Bench parameters: `TICK_DIV`=4, `SEL0_UNITS`=1, `MED_UNITS`=3, `HIGH_UNITS`=5, `SPIN_UNITS`=2.

- Reset mid-run: `RST`=1 asynchronously while `REMAIN`=2 → `REMAIN`=0, `TIMER_BUSY`=0, `TIMER_DONE`=0 immediately, before the next edge.
- Medium wash: `TIMER_SEL`=01, `TIMER_EN`=1 at load edge L → `REMAIN` sequence 3,2,1,0 at edges L, L+4, L+8, L+12; `TIMER_DONE` high for one cycle after L+12; `TIMER_BUSY` low after L+12.
- Hold after expiry: keep `TIMER_EN`=1 for 20 more cycles after the medium run → no second `TIMER_DONE`. Then drop `TIMER_EN`, set `TIMER_SEL`=11, raise `TIMER_EN` → `TIMER_DONE` 8 cycles after the new load.
- Abort: `TIMER_SEL`=10, drop `TIMER_EN` at L+10 → state IDLE, `REMAIN`=0, no `TIMER_DONE` over the next 30 cycles.
- Select change: `TIMER_SEL`=01 run, switch to 11 at L+5 → reload `REMAIN`=2 at edge L+5; `TIMER_DONE` at L+13.
- Simultaneous abort and expiry: `TIMER_SEL`=00, `TIMER_EN` falls exactly at L+4 → no `TIMER_DONE`, IDLE.
